uart_tx_frame_gen: RTL
======================

Name: uart_tx_frame_gen

Overview:
- UART transmitter, the companion of the team's UART_RX. Same frame format and the same PAR_EN/PAR_TYP/Prescale configuration, so TX_OUT can be looped straight into UART_RX.RX_IN.
- Accepts one parallel word per Data_Valid pulse and serialises it as: start bit, data bits LSB first, optional parity bit, stop bit.
- Each bit is held for Prescale clock cycles. One clock domain.

Parameters:
- WIDTH, 8, number of data bits per frame (package constant, overridable).

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST  input  1  reset; one clock, synchronous, active-high; clears all state on the CLK edge where RST=1.
- P_DATA  input  WIDTH  word to transmit; sampled when a frame is accepted.
- Data_Valid  input  1  request strobe; honoured only while Busy=0.
- PAR_EN  input  1  1 = parity bit inserted; sampled at acceptance.
- PAR_TYP  input  1  0 = even, 1 = odd parity; sampled at acceptance.
- Prescale  input  5  clock cycles per bit; sampled at acceptance; 0 is treated as 1.
- TX_OUT  output  1  serial line; idles high.
- Busy  output  1  high while a frame is on the line.

Behaviour:
- Reset values: TX_OUT=1, Busy=0, state IDLE, bit counter=0, prescale counter=0, shadow registers=0.
- Reset mid-frame aborts the frame; TX_OUT=1 and Busy=0 after that edge; nothing resumes.
- States and transitions:
  - IDLE → START on Data_Valid=1 with Busy=0.
  - START → DATA.
  - DATA → PARITY if the latched PAR_EN=1, else DATA → STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- Acceptance: at edge N (IDLE, Data_Valid=1) P_DATA, PAR_EN, PAR_TYP and Prescale are latched into shadow registers. TX_OUT=0 and Busy=1 after edge N.
- Bit timing: every bit lasts exactly P cycles (P = latched Prescale). The prescale counter runs 0..P-1; on its terminal count the machine advances to the next bit or state.
- DATA: bit k (k = 0..WIDTH-1) is driven from shadow[k]; the bit counter wraps after WIDTH-1.
- Parity bit = XOR of the shadow data, XOR the latched PAR_TYP. Even parity gives an even count of ones over data+parity; odd gives an odd count.
- Frame length F = 2 + WIDTH + PAR_EN bits. Busy is high for exactly F*P cycles. At edge N+F*P: state returns to IDLE, Busy=0, TX_OUT=1.
- Data_Valid while Busy=1 is ignored: no queueing, no error flag. Changes to inputs mid-frame have no effect.
- Back-to-back frames: Data_Valid sampled on the first edge with Busy=0 is accepted. This guarantees at least one high cycle between frames.
- Data_Valid held high continuously sends the current P_DATA repeatedly, each frame separated by one idle cycle.
- TX_OUT is registered (glitch-free). Its only value changes happen on bit boundaries.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: the STOP state emits two stop bits (2*P cycles high); F = 3 + WIDTH + PAR_EN.
- Undefined: one stop bit, as above.
- UART_RX accepts both forms; a second stop bit reads as idle.

Decomposition:
- Shared package / CONFIG_MACROS:
  - WIDTH.
  - EVEN_PARITY_CONFIG=0, ODD_PARITY_CONFIG=1 (shared with UART_RX).
  - State encodings IDLE/START/DATA/PARITY/STOP.
  - Prescale width 5.
- One natural sub-module: uart_tx_parity_calc. Combinational; inputs shadow data and PAR_TYP; output the parity bit. It mirrors the receiver's parity check and can be shared with it.

Test Plan:
- Odd parity, Prescale=16, P_DATA=0x7F, 1-cycle Data_Valid → TX_OUT = 0,1,1,1,1,1,1,1,0,0,1, each held 16 cycles. Busy high 176 cycles. Loopback UART_RX reports Data_Valid=1, P_DATA=0x7F.
- Even parity, same data → parity bit = 1, all other bits unchanged. PAR_EN=0 → 10 bits, Busy high 160 cycles, no parity slot.
- Prescale=8, P_DATA=0xA5, odd parity → bits 0,1,0,1,0,0,1,0,1,1,1, each 8 cycles. Busy high 88 cycles.
- Data_Valid pulsed 40 cycles into a frame with P_DATA=0x00 → ignored. The original frame is unchanged and no second frame follows.
- Data_Valid held high across two frames (0x7F then 0x55) → frames separated by exactly 1 idle-high cycle; the second start bit begins at edge F*P+1.
- RST=1 at cycle 50 of a frame → TX_OUT=1 and Busy=0 after that edge. A new Data_Valid afterwards produces a clean full frame.

Source files
------------

// File: rtl/uart_tx_frame_gen_pkg.sv
// Shared UART TX/RX configuration: data width, parity encodings, FSM states.
// Building with UART_TX_TWO_STOP_EN gives frames two stop bits.
package uart_tx_frame_gen_pkg;

  parameter int WIDTH = 8;
  localparam int PRESC_W = 5;

  localparam logic EVEN_PARITY_CONFIG = 1'b0;
  localparam logic ODD_PARITY_CONFIG  = 1'b1;

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Frame parity bit; same function the receiver uses to check parity.
module uart_tx_parity_calc #(
  parameter int WIDTH = uart_tx_frame_gen_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             par_typ_i,
  output logic             par_o
);

  // Odd type flips the result so data+parity has an odd count of ones.
  assign par_o = (^data_i) ^ par_typ_i;

endmodule

// File: rtl/uart_tx_frame_gen.sv
// UART transmitter: start, WIDTH data bits LSB first, optional parity, stop.
// UART_TX_TWO_STOP_EN selects two stop bits instead of one.
module uart_tx_frame_gen #(
  parameter int WIDTH = uart_tx_frame_gen_pkg::WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             Data_Valid,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic [4:0]       Prescale,
  output logic             TX_OUT,
  output logic             Busy
);
  import uart_tx_frame_gen_pkg::*;

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [BIT_W-1:0]   bit_q, bit_d, nxt_bit;
  logic [PRESC_W-1:0] cnt_q, cnt_d, presc_q, presc_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               paren_q, paren_d, partyp_q, partyp_d;
  logic               tx_q, tx_d;
  logic               par_bit, tick;

  uart_tx_parity_calc #(.WIDTH(WIDTH)) u_par (
    .data_i    (data_q),
    .par_typ_i (partyp_q),
    .par_o     (par_bit)
  );

  assign tick    = (cnt_q == presc_q - 1'b1);
  assign nxt_bit = bit_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    cnt_d    = cnt_q;
    presc_d  = presc_q;
    data_d   = data_q;
    paren_d  = paren_q;
    partyp_d = partyp_q;
    tx_d     = tx_q;
    if (state_q != IDLE) cnt_d = tick ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: if (Data_Valid) begin
        state_d  = START;
        tx_d     = 1'b0;
        data_d   = P_DATA;
        paren_d  = PAR_EN;
        partyp_d = PAR_TYP;
        presc_d  = (Prescale == '0) ? PRESC_W'(1) : Prescale;
        cnt_d    = '0;
        bit_d    = '0;
      end
      START: if (tick) begin
        state_d = DATA;
        tx_d    = data_q[0];
        bit_d   = '0;
      end
      DATA: if (tick) begin
        if (bit_q == BIT_W'(WIDTH - 1)) begin
          bit_d   = '0;
          state_d = paren_q ? PARITY : STOP;
          tx_d    = paren_q ? par_bit : 1'b1;
        end else begin
          bit_d = nxt_bit;
          tx_d  = data_q[nxt_bit];
        end
      end
      PARITY: if (tick) begin
        state_d = STOP;
        tx_d    = 1'b1;
        bit_d   = '0;
      end
      STOP: if (tick) begin
        // bit counter reused to count stop bits
        if (bit_q == BIT_W'(STOP_BITS - 1)) begin
          state_d = IDLE;
          bit_d   = '0;
        end else begin
          bit_d = nxt_bit;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      cnt_q    <= '0;
      presc_q  <= '0;
      data_q   <= '0;
      paren_q  <= 1'b0;
      partyp_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      presc_q  <= presc_d;
      data_q   <= data_d;
      paren_q  <= paren_d;
      partyp_q <= partyp_d;
      tx_q     <= tx_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = (state_q != IDLE);

endmodule
